// File: rtl/ula_contention.sv
// ula_contention: frame-timing and contention generator for the CPU clock path.
// Runs on the 28 MHz clock. It derives the 7 MHz pixel enable, the ZX-style
// horizontal and vertical counters and the frame interrupt. It is also the
// source end of the contention interface into the system clock block.
//
// Ports:
//   clk_28           28 MHz clock (the only clock)
//   reset_n          synchronous active-low reset
//   timing_128       1 = 128K timing, 0 = 48K timing (latched at frame wrap)
//   cpu_speed        CPU speed select; only 2'b00 (3.5 MHz) is contended
//   contention_en    global contention enable
//   contended_access current CPU access targets contended memory/IO
//   ce_7             single-cycle 7 MHz enable
//   hc, vc           pixel-clock horizontal counter, line counter
//   cpu_clk_lsb      3.5 MHz phase bit (hc[0])
//   cpu_contend      hold the contended CPU clock
//   int_n            frame interrupt, active low
module ula_contention #(
  parameter int unsigned LINES_48      = 312,
  parameter int unsigned LINES_128     = 311,
  parameter int unsigned CONT_LINE_48  = 64,
  parameter int unsigned CONT_LINE_128 = 63
) (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       timing_128,
  input  logic [1:0] cpu_speed,
  input  logic       contention_en,
  input  logic       contended_access,
  output logic       ce_7,
  output logic [8:0] hc,
  output logic [8:0] vc,
  output logic       cpu_clk_lsb,
  output logic       cpu_contend,
  output logic       int_n
);

  localparam logic [8:0] HMAX_48    = 9'd447;
  localparam logic [8:0] HMAX_128   = 9'd455;
  localparam logic [8:0] VMAX_48    = 9'(LINES_48 - 1);
  localparam logic [8:0] VMAX_128   = 9'(LINES_128 - 1);
  localparam logic [9:0] WIN_LO_48  = 10'(CONT_LINE_48);
  localparam logic [9:0] WIN_HI_48  = 10'(CONT_LINE_48 + 191);
  localparam logic [9:0] WIN_LO_128 = 10'(CONT_LINE_128);
  localparam logic [9:0] WIN_HI_128 = 10'(CONT_LINE_128 + 191);
  localparam logic [7:0] INT_T_48   = 8'd32;
  localparam logic [7:0] INT_T_128  = 8'd36;

  logic [1:0] div_q, div_d;
  logic       ce_7_q, ce_7_d;
  logic [8:0] hc_q, hc_d;
  logic [8:0] vc_q, vc_d;
  logic       mode_q, mode_d;
  logic       cpu_clk_lsb_q, cpu_clk_lsb_d;
  logic       cpu_contend_q, cpu_contend_d;
  logic       int_n_q, int_n_d;

  logic [8:0] hmax, vmax;
  logic       line_end, frame_end;
  logic [7:0] tc_d;
  logic [9:0] win_lo, win_hi;
  logic       win;

  // Prescaler: ce_7 is registered so it is high while div_q == 3.
  always_comb begin
    div_d  = div_q + 2'd1;
    ce_7_d = (div_q == 2'd2);
  end

  // Counter next state. Using >= gives the defensive wrap for free when a
  // counter is found beyond its range.
  always_comb begin
    hmax      = mode_q ? HMAX_128 : HMAX_48;
    vmax      = mode_q ? VMAX_128 : VMAX_48;
    line_end  = (hc_q >= hmax);
    frame_end = line_end && (vc_q >= vmax);
    hc_d      = hc_q;
    vc_d      = vc_q;
    mode_d    = mode_q;
    if (ce_7_q) begin
      if (line_end) begin
        hc_d = 9'd0;
        vc_d = (vc_q >= vmax) ? 9'd0 : vc_q + 9'd1;
      end else begin
        hc_d = hc_q + 9'd1;
        if (vc_q > vmax) vc_d = 9'd0;
      end
      if (frame_end) mode_d = timing_128;
    end
  end

  // Output next state, evaluated on the post-update counters and mode.
  always_comb begin
    tc_d   = hc_d[8:1];
    win_lo = mode_d ? WIN_LO_128 : WIN_LO_48;
    win_hi = mode_d ? WIN_HI_128 : WIN_HI_48;
    win    = ({1'b0, vc_d} >= win_lo) && ({1'b0, vc_d} <= win_hi) &&
             !tc_d[7] && (tc_d[2:0] < 3'd6);
    cpu_clk_lsb_d = cpu_clk_lsb_q;
    cpu_contend_d = cpu_contend_q;
    int_n_d       = int_n_q;
    if (ce_7_q) begin
      cpu_clk_lsb_d = hc_d[0];
      cpu_contend_d = win && contended_access && (cpu_speed == 2'b00) &&
                      contention_en;
      int_n_d       = !((vc_d == 9'd0) &&
                        (tc_d < (mode_d ? INT_T_128 : INT_T_48)));
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_28) begin
    if (!reset_n) begin
      div_q         <= 2'd0;
      ce_7_q        <= 1'b0;
      hc_q          <= 9'd0;
      vc_q          <= 9'd0;
      mode_q        <= timing_128;
      cpu_clk_lsb_q <= 1'b0;
      cpu_contend_q <= 1'b0;
      int_n_q       <= 1'b1;
    end else begin
      div_q         <= div_d;
      ce_7_q        <= ce_7_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mode_q        <= mode_d;
      cpu_clk_lsb_q <= cpu_clk_lsb_d;
      cpu_contend_q <= cpu_contend_d;
      int_n_q       <= int_n_d;
    end
  end

  assign ce_7        = ce_7_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign cpu_clk_lsb = cpu_clk_lsb_q;
  assign cpu_contend = cpu_contend_q;
  assign int_n       = int_n_q;

endmodule

// File: tb/tb_ula_contention.sv
// Directed bench for ula_contention. Frame heights are shortened via the
// parameters so whole frames fit in a short run; line lengths are fixed.
module tb_ula_contention;

  localparam int unsigned L48  = 6;
  localparam int unsigned L128 = 5;
  localparam int unsigned C48  = 2;
  localparam int unsigned C128 = 1;

  logic       clk_28 = 1'b0;
  logic       reset_n;
  logic       timing_128;
  logic [1:0] cpu_speed;
  logic       contention_en;
  logic       contended_access;
  logic       ce_7;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       cpu_clk_lsb;
  logic       cpu_contend;
  logic       int_n;

  int errors = 0;
  int checks = 0;

  // Reference counters: line/frame lengths and mode latching only.
  int   m_hc, m_vc, m_hmax, m_vmax;
  logic m_mode;
  int   trk_bad, int_low, cont_high;

  ula_contention #(
    .LINES_48(L48), .LINES_128(L128),
    .CONT_LINE_48(C48), .CONT_LINE_128(C128)
  ) dut (
    .clk_28(clk_28), .reset_n(reset_n), .timing_128(timing_128),
    .cpu_speed(cpu_speed), .contention_en(contention_en),
    .contended_access(contended_access), .ce_7(ce_7), .hc(hc), .vc(vc),
    .cpu_clk_lsb(cpu_clk_lsb), .cpu_contend(cpu_contend), .int_n(int_n)
  );

  always #5 clk_28 = ~clk_28;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode_model();
    m_hmax = m_mode ? 455 : 447;
    m_vmax = m_mode ? int'(L128) - 1 : int'(L48) - 1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "hc"},   32'(hc), 0);
    chk({pfx, "vc"},   32'(vc), 0);
    chk({pfx, "ce7"},  32'(ce_7), 0);
    chk({pfx, "lsb"},  32'(cpu_clk_lsb), 0);
    chk({pfx, "cont"}, 32'(cpu_contend), 0);
    chk({pfx, "intn"}, 32'(int_n), 1);
  endtask

  // Advance one 7 MHz period and sample just after the update edge.
  task automatic step();
    repeat (4) @(posedge clk_28);
    #1;
    if (m_hc == m_hmax) begin
      m_hc = 0;
      if (m_vc == m_vmax) begin
        m_vc   = 0;
        m_mode = timing_128;
        set_mode_model();
      end else begin
        m_vc++;
      end
    end else begin
      m_hc++;
    end
    if (hc !== 9'(m_hc) || vc !== 9'(m_vc) || cpu_clk_lsb !== m_hc[0] ||
        ce_7 !== 1'b0)
      trk_bad++;
    if (int_n === 1'b0) int_low++;
    if (cpu_contend === 1'b1) cont_high++;
  endtask

  initial begin
    reset_n = 1'b0; timing_128 = 1'b0; cpu_speed = 2'b00;
    contention_en = 1'b1; contended_access = 1'b1;
    repeat (2) @(posedge clk_28);
    #1;
    chk_reset("rst_");

    // Startup cadence: ce_7 high after the 3rd edge, first count on the 4th.
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_28);
      #1;
      chk("ce7_cadence", 32'(ce_7), (i % 4 == 3) ? 1 : 0);
      chk("hc_startup", 32'(hc), i / 4);
    end

    // Frame 1, 48K: line wrap, frame wrap and the contention pattern.
    m_hc = 2; m_vc = 0; m_mode = 1'b0; set_mode_model();
    trk_bad = 0; cont_high = 0;
    for (int p = 2; p < 2688; p++) begin
      step();
      if (m_vc == 1 && m_hc == 0) begin
        chk("hwrap48_hc", 32'(hc), 0);
        chk("hwrap48_vc", 32'(vc), 1);
        chk("cont_line_before", 32'(cpu_contend), 0);
      end
      if (m_vc == 5 && m_hc == 447) chk("vmax48", 32'(vc), 5);
      if (m_vc == int'(C48)) begin
        case (m_hc)
          0:   chk("cont_tc0",   32'(cpu_contend), 1);
          11:  chk("cont_tc5",   32'(cpu_contend), 1);
          12:  chk("cont_tc6",   32'(cpu_contend), 0);
          15:  chk("cont_tc7",   32'(cpu_contend), 0);
          16:  chk("cont_tc8",   32'(cpu_contend), 1);
          250: chk("cont_tc125", 32'(cpu_contend), 1);
          254: chk("cont_tc127", 32'(cpu_contend), 0);
          256: chk("cont_tc128", 32'(cpu_contend), 0);
          default: ;
        endcase
      end
    end
    chk("frame48_hc", 32'(hc), 0);
    chk("frame48_vc", 32'(vc), 0);
    chk("cont_count48", 32'(cont_high), 768);
    chk("track_f1", 32'(trk_bad), 0);

    // Frame 2, 48K: gating inputs, then a mid-frame switch to 128K.
    trk_bad = 0; int_low = 0;
    for (int p = 0; p < 2688; p++) begin
      if (m_vc == 1 && m_hc == 447) cpu_speed = 2'b01;
      if (m_vc == 2 && m_hc == 31)  cpu_speed = 2'b00;
      if (m_vc == 2 && m_hc == 33)  contended_access = 1'b0;
      if (m_vc == 2 && m_hc == 39)  contended_access = 1'b1;
      if (m_vc == 2 && m_hc == 41)  contention_en = 1'b0;
      if (m_vc == 2 && m_hc == 43)  contention_en = 1'b1;
      if (m_vc == 3 && m_hc == 0)   timing_128 = 1'b1;
      step();
      if (m_vc == 2) begin
        case (m_hc)
          0:  chk("speed01_tc0",  32'(cpu_contend), 0);
          10: chk("speed01_tc5",  32'(cpu_contend), 0);
          32: chk("speed00_tc16", 32'(cpu_contend), 1);
          33: chk("pre_drop",     32'(cpu_contend), 1);
          34: chk("access_drop",  32'(cpu_contend), 0);
          40: chk("access_back",  32'(cpu_contend), 1);
          42: chk("en_off",       32'(cpu_contend), 0);
          default: ;
        endcase
      end
      if (m_vc == 4 && m_hc == 0) begin
        chk("mode_hold_hc", 32'(hc), 0);
        chk("mode_hold_vc", 32'(vc), 4);
      end
      if (m_vc == 5 && m_hc == 447) chk("vmax48_f2", 32'(vc), 5);
    end
    chk("frame2_hc", 32'(hc), 0);
    chk("frame2_vc", 32'(vc), 0);
    chk("int_low48", 32'(int_low), 64);
    chk("track_f2", 32'(trk_bad), 0);

    // Frame 3, 128K: longer lines, shorter frame, 36 T-state interrupt.
    trk_bad = 0; int_low = 0;
    for (int p = 0; p < 2280; p++) begin
      step();
      if (m_vc == 0 && m_hc == 448) chk("hc_past_447", 32'(hc), 448);
      if (m_vc == 0 && m_hc == 71)  chk("int_last128", 32'(int_n), 0);
      if (m_vc == 0 && m_hc == 72)  chk("int_end128",  32'(int_n), 1);
      if (m_vc == 1 && m_hc == 0) begin
        chk("hwrap128_vc", 32'(vc), 1);
        chk("cont_line1_128", 32'(cpu_contend), 1);
      end
      if (m_vc == 4 && m_hc == 455) begin
        chk("hmax128", 32'(hc), 455);
        chk("vmax128", 32'(vc), 4);
      end
    end
    chk("frame128_hc", 32'(hc), 0);
    chk("frame128_vc", 32'(vc), 0);
    chk("int_low128", 32'(int_low), 72);
    chk("track_f3", 32'(trk_bad), 0);

    // Mid-frame reset between enables; 48K selected while in reset.
    for (int p = 0; p < 3000 && !(m_vc == 3 && m_hc == 300); p++) step();
    chk("reach_mid_vc", 32'(vc), 3);
    chk("reach_mid_hc", 32'(hc), 300);
    repeat (2) @(posedge clk_28);
    #1;
    reset_n = 1'b0; timing_128 = 1'b0;
    @(posedge clk_28);
    #1;
    chk_reset("midrst_");
    reset_n = 1'b1;
    repeat (3) @(posedge clk_28);
    #1;
    chk("midrst_ce7_first", 32'(ce_7), 1);
    chk("midrst_hc_hold", 32'(hc), 0);
    @(posedge clk_28);
    #1;
    chk("midrst_hc_first", 32'(hc), 1);
    chk("midrst_ce7_low", 32'(ce_7), 0);
    m_hc = 1; m_vc = 0; m_mode = 1'b0; set_mode_model();
    trk_bad = 0;
    for (int p = 0; p < 447; p++) step();
    chk("rst_mode48_hc", 32'(hc), 0);
    chk("rst_mode48_vc", 32'(vc), 1);
    chk("track_f4", 32'(trk_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_contention.md
# ula_contention

Frame-timing and contention generator for the CPU clock path. It runs on the 28 MHz clock and derives a 7 MHz pixel enable, ZX-compatible horizontal/vertical counters and the frame interrupt. It drives `cpu_clk_lsb` and `cpu_contend` into the system clock block, which uses them to gate the contended 3.5 MHz CPU clock. This block is the source end of that contention interface; the system clock block is its consumer.

## Interface
- `LINES_48`, default 312: lines per frame, 48K timing.
- `LINES_128`, default 311: lines per frame, 128K timing.
- `CONT_LINE_48`, default 64: first contended line, 48K timing.
- `CONT_LINE_128`, default 63: first contended line, 128K timing.
- `clk_28`  in  1  28 MHz clock; the only clock in this block.
- `reset_n`  in  1  synchronous active-low reset.
- `timing_128`  in  1  1 selects 128K timing; 0 selects 48K timing.
- `cpu_speed`  in  2  CPU speed select; 00 = 3.5 MHz, the only speed that is contended.
- `contention_en`  in  1  global contention enable.
- `contended_access`  in  1  current CPU access targets contended memory or I/O (from the memory decoder).
- `ce_7`  out  1  single-cycle 7 MHz enable pulse.
- `hc`  out  9  pixel-clock horizontal counter.
- `vc`  out  9  line counter.
- `cpu_clk_lsb`  out  1  3.5 MHz phase bit.
- `cpu_contend`  out  1  hold the contended CPU clock.
- `int_n`  out  1  frame interrupt, active low.

## Operation
- Prescaler: 2-bit `div` increments every `clk_28` cycle. `ce_7` = 1 when `div` = 3 (1 cycle in 4).
- Line length: `hmax` = 447 in 48K mode (224 T-states per line), 455 in 128K mode (228 T-states per line).
- Frame length: `vmax` = `LINES_48`-1 or `LINES_128`-1.
- Horizontal counter, on `ce_7`: if `hc` = `hmax`, set `hc` to 0 and advance `vc`; otherwise increment `hc`.
- Vertical counter: `vc` wraps `vmax` -> 0.
- Mode latch: `timing_128` is latched into `mode_q` only at the frame wrap (`hc` = `hmax` and `vc` = `vmax` on `ce_7`) and at reset. A mid-frame change of `timing_128` has no effect until the next frame.
- Phase bit: `cpu_clk_lsb` = `hc[0]`.
- T-state: `tc` = `hc[8:1]`.
- Contention window `win` is true when all of the following hold:
  - `vc` is in [`first`, `first`+191], where `first` = `CONT_LINE_48` or `CONT_LINE_128` per `mode_q`;
  - `tc` < 128;
  - `tc[2:0]` < 6.
- Contention output: `cpu_contend` = `win` & `contended_access` & (`cpu_speed` = 00) & `contention_en`.
  - Computed from the post-update counters and registered on `ce_7`.
  - The window pattern gives per-8-T-state delays of 6,5,4,3,2,1,0,0.
- Interrupt: `int_n` = 0 when `vc` = 0 and `tc` < 32 (48K) or `tc` < 36 (128K); registered on `ce_7`.
- Defensive wrap: a counter found outside its range (`hc` > `hmax` or `vc` > `vmax`, e.g. after a mode change) wraps to 0 on the next `ce_7`.

## Timing
- Reset values: `div`=0, `hc`=0, `vc`=0, `ce_7`=0, `cpu_clk_lsb`=0, `cpu_contend`=0, `int_n`=1, `mode_q`=`timing_128`.
- Reset takes effect at the `clk_28` edge where `reset_n` is 0. It overrides every other event, including a reset asserted in the middle of a line or frame.
- The first `ce_7` occurs 4 cycles after `reset_n` rises.
- All registered outputs change only on the `clk_28` edge where `ce_7` = 1, except `ce_7` itself.
- Outputs are stable for 4 `clk_28` cycles, so the 7 MHz consumer samples stable values.
- `cpu_contend` latency: a change on `contended_access`, `cpu_speed` or `contention_en` appears at the next `ce_7` edge. Inputs are sampled only at that edge.
- Simultaneous line wrap and frame wrap: `hc`, `vc` and `mode_q` all update on the same edge.
- Frame period:
  - 48K: 448×312 = 139776 `ce_7` pulses (69888 T-states).
  - 128K: 456×311 = 141816 `ce_7` pulses (70908 T-states).

## Test plan
- Reset, then run in 48K mode:
  - `ce_7` pulses every 4th cycle;
  - `hc` wraps 447->0 with `vc` incrementing;
  - a `vc` wrap 311->0 occurs every 139776 pulses.
- 128K mode:
  - `hc` wraps at 455 and `vc` wraps at 310;
  - frame length = 141816 pulses;
  - `int_n` is low for exactly 72 pulses (36 T-states) starting at `vc`=0, `hc`=0.
- 48K contention, with `contended_access`=1, `cpu_speed`=00, `contention_en`=1:
  - on line 64, `cpu_contend`=1 for `tc` 0–5, 0 for `tc` 6–7, repeating;
  - `cpu_contend`=0 at `tc` ≥ 128, on line 63, and on line 256.
- Contention gating:
  - `cpu_speed`=01 with all other contention conditions met -> `cpu_contend` stays 0;
  - `contended_access` dropped mid-window -> `cpu_contend` falls at the next `ce_7`.
- Mode switch: toggle `timing_128` at `vc`=100 -> line length is unchanged until the `vc` wrap, then changes on the first line of the new frame.
- Mid-frame reset: assert `reset_n`=0 at `vc`=200, `hc`=300 for 1 cycle -> all counters and outputs at reset values on the next edge; counting resumes with the first `ce_7` 4 cycles after `reset_n` rises.
